if_stage: RTL



---
 rtl/if_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, single-outstanding inst-SRAM fetch, delay-slot branch redirect.
// Define FS_ADEL_EN to stop fetching and flag fs_ex_adel when the next PC is misaligned.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic [33:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_ex_adel
);

    typedef enum logic [1:0] {PF_IDLE, PF_REQ, PF_WAIT, PF_HOLD} pf_state_t;
    typedef enum logic [1:0] {BR_NONE, BR_WAIT_SLOT, BR_READY} br_state_t;

    pf_state_t   pf_state, pf_next;
    br_state_t   br_state, br_next;
    logic [31:0] req_pc, br_target_r, nextpc;
    logic        cancel;
    logic        fs_valid, rbuf_valid;
    logic [31:0] fs_inst, fs_pc, rbuf_inst, rbuf_pc;

    logic        br_stall, br_taken, br_fire;
    logic [31:0] br_target;
    logic        hs, resp, fs_load_en, kill_slot, drop, keep, rbuf_use, adel_hit;

    assign {br_stall, br_taken, br_target} = br_bus;
    assign br_fire = br_taken & !br_stall;

    assign nextpc         = (br_state == BR_READY) ? br_target_r : req_pc + 32'd4;
    assign inst_sram_addr = nextpc;

`ifdef FS_ADEL_EN
    logic adel_stop, fs_adel;
    assign adel_hit      = (pf_state == PF_REQ) & (nextpc[1:0] != 2'b00) & !adel_stop;
    assign inst_sram_req = (pf_state == PF_REQ) & (nextpc[1:0] == 2'b00) & !adel_stop;
    assign fs_ex_adel    = fs_valid & fs_adel;
`else
    assign adel_hit      = 1'b0;
    assign inst_sram_req = (pf_state == PF_REQ);
    assign fs_ex_adel    = 1'b0;
`endif

    assign hs         = inst_sram_req & inst_sram_addr_ok;
    assign resp       = (pf_state == PF_WAIT) & inst_sram_data_ok;
    assign fs_load_en = !fs_valid | ds_allowin;
    // Delay slot sits in FS, so anything fetched after it (rbuf or in flight) is wrong-path.
    assign kill_slot  = br_fire & (br_state == BR_NONE) & fs_valid;
    assign drop       = resp & (cancel | kill_slot);
    assign keep       = resp & !drop;
    assign rbuf_use   = rbuf_valid & !kill_slot;

    assign fs_to_ds_valid = fs_valid;
    assign fs_to_ds_bus   = {fs_inst, fs_pc};

    always_comb begin
        pf_next = pf_state;
        case (pf_state)
            PF_IDLE: pf_next = PF_REQ;
            PF_REQ:  if (hs) pf_next = PF_WAIT;
            PF_WAIT: if (resp) pf_next = (keep & !fs_load_en) ? PF_HOLD : PF_REQ;
            PF_HOLD: if (fs_load_en | kill_slot) pf_next = PF_REQ;
            default: pf_next = PF_IDLE;
        endcase
    end

    // A handshake this cycle counts as accepted before the branch is classified.
    always_comb begin
        br_next = br_state;
        case (br_state)
            BR_NONE: begin
                if (br_fire) begin
                    if (fs_valid | rbuf_valid | hs | (pf_state == PF_WAIT) | (pf_state == PF_HOLD))
                        br_next = BR_READY;
                    else
                        br_next = BR_WAIT_SLOT;
                end
            end
            BR_WAIT_SLOT: if (hs) br_next = BR_READY;
            BR_READY:     if (hs) br_next = BR_NONE;
            default:      br_next = BR_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pf_state    <= PF_IDLE;
            br_state    <= BR_NONE;
            req_pc      <= RESET_PC - 32'd4;
            br_target_r <= '0;
            cancel      <= 1'b0;
        end else begin
            pf_state <= pf_next;
            br_state <= br_next;
            if (hs)
                req_pc <= nextpc;
            if ((br_state == BR_NONE) & br_fire)
                br_target_r <= br_target;
            if (kill_slot & (hs | ((pf_state == PF_WAIT) & !resp)))
                cancel <= 1'b1;
            else if (resp)
                cancel <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fs_valid   <= 1'b0;
            fs_inst    <= '0;
            fs_pc      <= '0;
            rbuf_valid <= 1'b0;
            rbuf_inst  <= '0;
            rbuf_pc    <= '0;
        end else begin
            if (fs_load_en) begin
                if (rbuf_use) begin
                    fs_valid <= 1'b1;
                    fs_inst  <= rbuf_inst;
                    fs_pc    <= rbuf_pc;
                end else if (keep) begin
                    fs_valid <= 1'b1;
                    fs_inst  <= inst_sram_rdata;
                    fs_pc    <= req_pc;
                end else if (adel_hit) begin
                    fs_valid <= 1'b1;
                    fs_inst  <= '0;
                    fs_pc    <= nextpc;
                end else begin
                    fs_valid <= 1'b0;
                end
            end
            if (rbuf_valid & (fs_load_en | kill_slot)) begin
                rbuf_valid <= 1'b0;
            end else if (keep & !fs_load_en) begin
                rbuf_valid <= 1'b1;
                rbuf_inst  <= inst_sram_rdata;
                rbuf_pc    <= req_pc;
            end
        end
    end

`ifdef FS_ADEL_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            adel_stop <= 1'b0;
            fs_adel   <= 1'b0;
        end else if (fs_load_en) begin
            fs_adel <= adel_hit & !rbuf_use & !keep;
            if (adel_hit & !rbuf_use & !keep)
                adel_stop <= 1'b1;
        end
    end
`endif

endmodule
